fp_to_int_simd: RTL and testbench
=================================

Name: fp_to_int_simd

Overview:
- Lane-parallel, parameterised-latency float-to-integer conversion unit for the SM FPU pipeline.
- Takes NUM_LANES fp32 operands per transaction and converts each through one fp_to_int_core instance (EXPWIDTH=8, PRECISION=24).
- Carries a per-transaction lane mask and an opaque control tag, and returns per-lane results plus OR-merged exception flags.
- Replaces the single-lane fixed-latency converter. Adds a fully stallable valid/ready pipeline with bubble collapse, lane masking, tag passthrough and occupancy reporting.

Parameters:
- NUM_LANES, 4: number of parallel 32-bit lanes.
- STAGES, 2: total latency in cycles, legal range 2..4. Other values fail elaboration.
- TAG_WIDTH, 8: width of the opaque control tag (regindex/warpid/wvd/wxd bundle).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid_i  in  1  transaction offered.
- in_ready_o  out  1  unit accepts the transaction this cycle.
- op_i  in  3  op[2]=1 selects double (unsupported); op[1:0] is the core op (00 fcvt.w.s, 01 fcvt.wu.s).
- rm_i  in  3  RISC-V rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM).
- a_i  in  32*NUM_LANES  lane i occupies bits [32i+31:32i].
- mask_i  in  NUM_LANES  lane-active bits.
- tag_i  in  TAG_WIDTH  control tag.
- out_valid_o  out  1  result available.
- out_ready_i  in  1  consumer accepts the result.
- result_o  out  32*NUM_LANES  per-lane integer results.
- fflags_o  out  5  {NV,DZ,OF,UF,NX}, OR over active lanes.
- mask_o  out  NUM_LANES  mask of the output transaction.
- tag_o  out  TAG_WIDTH  tag of the output transaction.
- occupancy_o  out  $clog2(STAGES+1)  number of valid stages.

Behaviour:
- Reset: asynchronous on rst_n low; every stage register goes to 0.
  - out_valid_o=0, result_o=0, fflags_o=0, mask_o=0, tag_o=0, occupancy_o=0.
  - in_ready_o=1 while rst_n is high after reset.
  - Reset asserted mid-flight discards all in-flight transactions; no output is produced for them.
- Pipeline structure: stage 0 registers {op, rm, a, mask, tag} on acceptance. The core array evaluates combinationally on stage-0 contents. Stage 1 registers the core outputs; stages 2..STAGES-1 are pure delay. The output comes from stage STAGES-1.
- Latency is exactly STAGES cycles from the accept edge to out_valid_o when there are no stalls.
- Per-stage valid v[k]; rdy[STAGES] = out_ready_i; rdy[k] = !v[k] || rdy[k+1]; in_ready_o = rdy[0].
  - Stage k loads from k-1 when rdy[k]; otherwise it holds.
  - v[k] next = v[k-1] when rdy[k], else v[k].
  - Bubbles collapse: a stalled output does not block upstream stages that still have empty slots.
- Accept occurs when in_valid_i && in_ready_o. Output transfer occurs when out_valid_o && out_ready_i.
- Simultaneous transfer-out and accept with all stages full is legal; full throughput is 1 transaction per cycle.
- Output registers hold stable while out_valid_o && !out_ready_i.
- occupancy_o = popcount(v). It equals STAGES when full, at which point in_ready_o = out_ready_i.
- Lane rules:
  - Inactive lane (mask bit 0): result 0, contributes nothing to fflags.
  - op[2]=1: all lanes give result 0, fflags_o=0; mask and tag still pass through.
  - fflags_o = OR of core flags over active lanes; 0 if no lane is active.
- Conversion follows RISC-V semantics.
  - Signed out-of-range, NaN or +Inf: 0x7FFFFFFF with NV. -Inf or negative overflow: 0x80000000 with NV.
  - Unsigned negative (rounded value < 0): 0 with NV. Unsigned NaN, overflow or +Inf: 0xFFFFFFFF with NV.
  - Any inexact in-range result sets NX.
- No X propagation: stage data registers update only when the stage loads.

Test Plan:
- Single lane, STAGES=2, a=0x3FC00000 (1.5), rm=000, op=000, mask=0001, tag=0x5A, out_ready_i=1 → out_valid_o exactly 2 cycles after accept; lane0=0x00000002, fflags=0x01, tag_o=0x5A.
- Four lanes, a={0x4F32D05E, 0xBF800000, 0x7FC00000, 0x402CCCCD}, lanes 3..0, op=000, rm=001, mask=1111 → results {0x7FFFFFFF, 0xFFFFFFFF, 0x7FFFFFFF, 0x00000002}, fflags=0x11. Repeat with mask=0001 → fflags=0x01 and lanes 1..3 = 0.
- Unsigned: op=001, lane0=0xBF800000 (-1.0) → 0x00000000, NV (fflags=0x10). op=101 (double) → result 0, fflags 0, tag preserved.
- Backpressure, STAGES=4: send 6 back-to-back, out_ready_i=0 → accepts exactly 4, occupancy_o=4, in_ready_o=0. Raise out_ready_i → 6 outputs in order with tags intact, none duplicated or dropped.
- Bubble collapse: send tx A, idle 2 cycles, send B, hold out_ready_i=0 → B reaches stage STAGES-2 and stays adjacent to A; occupancy_o=2.
- Reset pulse with 3 transactions in flight → outputs 0 within the same cycle, occupancy_o=0. No stale output after rst_n deasserts; the next transaction emerges normally.

Source files
------------

// File: rtl/fp_to_int_simd.sv
// Lane-parallel fp32 -> int32/uint32 converter with a stallable valid/ready pipeline.
// One fp_to_int_core per lane; mask, tag and OR-merged flags travel with each transaction.

module fp_to_int_core #(
    parameter int unsigned EXPWIDTH  = 8,
    parameter int unsigned PRECISION = 24
) (
    input  logic [EXPWIDTH+PRECISION-1:0] a,
    input  logic [2:0]                    rm,
    input  logic [1:0]                    op,
    output logic [31:0]                   result_c,
    output logic [4:0]                    fflags_c
);
    localparam int unsigned MANT_W = PRECISION - 1;
    localparam int unsigned BIAS   = (1 << (EXPWIDTH - 1)) - 1;
    localparam int unsigned FX_W   = 64;
    // Shift that places the integer part of the significand in fx[63:32].
    localparam int unsigned SH_OFF = BIAS + MANT_W - 32;

    logic                  sign;
    logic [EXPWIDTH-1:0]   exp_f;
    logic [EXPWIDTH-1:0]   eff_exp;
    logic [EXPWIDTH-1:0]   sh;
    logic [MANT_W-1:0]     frac;
    logic [PRECISION-1:0]  mant;
    logic                  is_nan;
    logic                  too_big;
    logic [FX_W-1:0]       fx;
    logic [31:0]           int_mag;
    logic                  rnd_bit;
    logic                  sticky;
    logic                  inexact;
    logic                  inc;
    logic [32:0]           rmag;
    logic                  unused_op;

    assign unused_op = op[1];

    always_comb begin
        sign     = a[EXPWIDTH+MANT_W];
        exp_f    = a[EXPWIDTH+MANT_W-1 -: EXPWIDTH];
        frac     = a[MANT_W-1:0];
        mant     = {(exp_f != '0), frac};
        eff_exp  = (exp_f == '0) ? EXPWIDTH'(1) : exp_f;
        is_nan   = (&exp_f) && (frac != '0);
        too_big  = eff_exp >= EXPWIDTH'(BIAS + 32);
        sh       = eff_exp - EXPWIDTH'(SH_OFF);
        fx       = '0;
        int_mag  = '0;
        rnd_bit  = 1'b0;
        sticky   = 1'b0;
        inc      = 1'b0;
        result_c = '0;
        fflags_c = '0;

        // Magnitudes below 0.5 only contribute sticky; exactly [0.5,1) has the round bit set.
        if (eff_exp >= EXPWIDTH'(BIAS)) begin
            fx      = FX_W'(mant) << sh;
            int_mag = fx[FX_W-1:32];
            rnd_bit = fx[31];
            sticky  = |fx[30:0];
        end else if (eff_exp == EXPWIDTH'(BIAS - 1)) begin
            rnd_bit = 1'b1;
            sticky  = |frac;
        end else begin
            sticky  = |mant;
        end
        inexact = rnd_bit | sticky;

        case (rm)
            3'b000:  inc = rnd_bit & (sticky | int_mag[0]);
            3'b010:  inc = sign & inexact;
            3'b011:  inc = ~sign & inexact;
            3'b100:  inc = rnd_bit;
            default: inc = 1'b0;
        endcase
        rmag = {1'b0, int_mag} + 33'(inc);

        if (!op[0]) begin
            if (is_nan) begin
                result_c = 32'h7FFF_FFFF;
                fflags_c = 5'b10000;
            end else if (too_big) begin
                result_c = sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
                fflags_c = 5'b10000;
            end else if (!sign && (rmag > 33'h0_7FFF_FFFF)) begin
                result_c = 32'h7FFF_FFFF;
                fflags_c = 5'b10000;
            end else if (sign && (rmag > 33'h0_8000_0000)) begin
                result_c = 32'h8000_0000;
                fflags_c = 5'b10000;
            end else begin
                result_c = sign ? (~rmag[31:0]) + 32'd1 : rmag[31:0];
                fflags_c = {4'b0000, inexact};
            end
        end else begin
            if (is_nan) begin
                result_c = 32'hFFFF_FFFF;
                fflags_c = 5'b10000;
            end else if (too_big) begin
                result_c = sign ? 32'h0000_0000 : 32'hFFFF_FFFF;
                fflags_c = 5'b10000;
            end else if (sign && (rmag != '0)) begin
                result_c = 32'h0000_0000;
                fflags_c = 5'b10000;
            end else if (rmag[32]) begin
                result_c = 32'hFFFF_FFFF;
                fflags_c = 5'b10000;
            end else begin
                result_c = rmag[31:0];
                fflags_c = {4'b0000, inexact};
            end
        end
    end
endmodule

module fp_to_int_simd #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned STAGES    = 2,
    parameter int unsigned TAG_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [2:0]                   op_i,
    input  logic [2:0]                   rm_i,
    input  logic [32*NUM_LANES-1:0]      a_i,
    input  logic [NUM_LANES-1:0]         mask_i,
    input  logic [TAG_WIDTH-1:0]         tag_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [32*NUM_LANES-1:0]      result_o,
    output logic [4:0]                   fflags_o,
    output logic [NUM_LANES-1:0]         mask_o,
    output logic [TAG_WIDTH-1:0]         tag_o,
    output logic [$clog2(STAGES+1)-1:0]  occupancy_o
);
    localparam int unsigned DATA_W = 32 * NUM_LANES;
    localparam int unsigned OCC_W  = $clog2(STAGES + 1);

    typedef struct packed {
        logic [2:0]           op;
        logic [2:0]           rm;
        logic [DATA_W-1:0]    a;
        logic [NUM_LANES-1:0] mask;
        logic [TAG_WIDTH-1:0] tag;
    } in_pl_t;

    typedef struct packed {
        logic [DATA_W-1:0]    result;
        logic [4:0]           fflags;
        logic [NUM_LANES-1:0] mask;
        logic [TAG_WIDTH-1:0] tag;
    } out_pl_t;

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("fp_to_int_simd: STAGES must be in 2..4");
    end

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] v_next;
    logic [STAGES-1:0] rdy;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W-1:0]  occ_next;
    logic              all_full;
    in_pl_t            s0;
    out_pl_t           st [1:STAGES-1];
    out_pl_t           core_pl;
    logic [31:0]       lane_res   [NUM_LANES];
    logic [4:0]        lane_flags [NUM_LANES];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        fp_to_int_core #(
            .EXPWIDTH  (8),
            .PRECISION (24)
        ) u_core (
            .a        (s0.a[32*i +: 32]),
            .rm       (s0.rm),
            .op       (s0.op[1:0]),
            .result_c (lane_res[i]),
            .fflags_c (lane_flags[i])
        );
    end

    // Masked / unsupported lanes yield zero and contribute no flags.
    always_comb begin
        core_pl      = '0;
        core_pl.mask = s0.mask;
        core_pl.tag  = s0.tag;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (s0.mask[i] && !s0.op[2]) begin
                core_pl.result[32*i +: 32] = lane_res[i];
                core_pl.fflags             = core_pl.fflags | lane_flags[i];
            end
        end
    end

    // A stage may load when it or any stage downstream has a free slot.
    always_comb begin
        rdy      = '0;
        all_full = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--) begin
            all_full = all_full & v[k];
            rdy[k]   = out_ready_i | ~all_full;
        end
    end

    always_comb begin
        v_next    = v;
        occ_next  = '0;
        v_next[0] = rdy[0] ? in_valid_i : v[0];
        for (int k = 1; k < STAGES; k++) begin
            if (rdy[k]) begin
                v_next[k] = v[k-1];
            end
        end
        for (int k = 0; k < STAGES; k++) begin
            occ_next = occ_next + OCC_W'(v_next[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v   <= '0;
            occ <= '0;
            s0  <= '0;
            for (int k = 1; k < STAGES; k++) begin
                st[k] <= '0;
            end
        end else begin
            v   <= v_next;
            occ <= occ_next;
            if (rdy[0] && in_valid_i) begin
                s0 <= {op_i, rm_i, a_i, mask_i, tag_i};
            end
            if (rdy[1] && v[0]) begin
                st[1] <= core_pl;
            end
            for (int k = 2; k < STAGES; k++) begin
                if (rdy[k] && v[k-1]) begin
                    st[k] <= st[k-1];
                end
            end
        end
    end

    assign in_ready_o  = rdy[0];
    assign out_valid_o = v[STAGES-1];
    assign result_o    = st[STAGES-1].result;
    assign fflags_o    = st[STAGES-1].fflags;
    assign mask_o      = st[STAGES-1].mask;
    assign tag_o       = st[STAGES-1].tag;
    assign occupancy_o = occ;
endmodule

// File: tb/tb_fp_to_int_simd.sv
// Directed bench for fp_to_int_simd: a STAGES=2 instance for conversion/latency and a
// STAGES=4 instance for backpressure, bubble collapse and mid-flight reset.
`timescale 1ns/1ps
module tb_fp_to_int_simd;
    localparam int unsigned NL = 4;
    localparam int unsigned TW = 8;
    localparam int unsigned DW = 32 * NL;

    typedef struct packed {
        logic [DW-1:0] res;
        logic [4:0]    ff;
        logic [NL-1:0] mask;
        logic [TW-1:0] tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    op, rm;
    logic [DW-1:0] a;
    logic [NL-1:0] mask;
    logic [TW-1:0] tag;
    logic          iv2, iv4, ordy2, ordy4;
    logic          ir2, ir4, ov2, ov4;
    logic [DW-1:0] res2, res4;
    logic [4:0]    ff2, ff4;
    logic [NL-1:0] mo2, mo4;
    logic [TW-1:0] to2, to4;
    logic [1:0]    occ2;
    logic [2:0]    occ4;

    exp_t q2[$];
    exp_t q4[$];
    exp_t e2, e4;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int nout2 = 0;
    int nout4 = 0;
    int acc_cyc = 0;
    logic [31:0] flt [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                             32'h40800000, 32'h40A00000, 32'h40C00000};

    fp_to_int_simd #(.NUM_LANES(NL), .STAGES(2), .TAG_WIDTH(TW)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(iv2), .in_ready_o(ir2), .op_i(op), .rm_i(rm),
        .a_i(a), .mask_i(mask), .tag_i(tag), .out_valid_o(ov2), .out_ready_i(ordy2),
        .result_o(res2), .fflags_o(ff2), .mask_o(mo2), .tag_o(to2), .occupancy_o(occ2));

    fp_to_int_simd #(.NUM_LANES(NL), .STAGES(4), .TAG_WIDTH(TW)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(iv4), .in_ready_o(ir4), .op_i(op), .rm_i(rm),
        .a_i(a), .mask_i(mask), .tag_i(tag), .out_valid_o(ov4), .out_ready_i(ordy4),
        .result_o(res4), .fflags_o(ff4), .mask_o(mo4), .tag_o(to4), .occupancy_o(occ4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Scoreboard: pop and compare on every output transfer.
    always @(negedge clk) begin
        if (rst_n && ov2 && ordy2) begin
            nout2++;
            checks++;
            assert (q2.size() != 0) else begin
                errors++;
                $error("FAIL dut2_unexpected: observed tag %0h expected no output", to2);
            end
            if (q2.size() != 0) begin
                e2 = q2.pop_front();
                check("dut2_result", res2, e2.res);
                check("dut2_fflags", DW'(ff2), DW'(e2.ff));
                check("dut2_mask", DW'(mo2), DW'(e2.mask));
                check("dut2_tag", DW'(to2), DW'(e2.tag));
            end
        end
        if (rst_n && ov4 && ordy4) begin
            nout4++;
            checks++;
            assert (q4.size() != 0) else begin
                errors++;
                $error("FAIL dut4_unexpected: observed tag %0h expected no output", to4);
            end
            if (q4.size() != 0) begin
                e4 = q4.pop_front();
                check("dut4_result", res4, e4.res);
                check("dut4_fflags", DW'(ff4), DW'(e4.ff));
                check("dut4_mask", DW'(mo4), DW'(e4.mask));
                check("dut4_tag", DW'(to4), DW'(e4.tag));
            end
        end
    end

    task automatic set_tx(input logic [2:0] o, input logic [2:0] r, input logic [DW-1:0] av,
                          input logic [NL-1:0] m, input logic [TW-1:0] t);
        op = o; rm = r; a = av; mask = m; tag = t;
    endtask

    // Holds in_valid until accepted; returns at posedge+1 with in_valid still high.
    task automatic offer(input int which, input exp_t e);
        bit done = 1'b0;
        if (which == 2) iv2 = 1'b1; else iv4 = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if ((which == 2 && ir2) || (which == 4 && ir4)) begin
                if (which == 2) q2.push_back(e); else q4.push_back(e);
                acc_cyc = cyc;
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL accept_timeout: observed no accept expected accept of tag %0h", e.tag);
        end
    endtask

    task automatic send(input int which, input logic [2:0] o, input logic [2:0] r,
                        input logic [DW-1:0] av, input logic [NL-1:0] m, input logic [TW-1:0] t,
                        input logic [DW-1:0] eres, input logic [4:0] eff);
        set_tx(o, r, av, m, t);
        offer(which, exp_t'({eres, eff, m, t}));
    endtask

    task automatic idle(input int n);
        iv2 = 1'b0; iv4 = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int n = 0;
        iv2 = 1'b0; iv4 = 1'b0;
        while ((q2.size() != 0 || q4.size() != 0) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        assert (q2.size() == 0 && q4.size() == 0) else begin
            errors++;
            $error("FAIL drain: observed %0d/%0d pending expected 0/0", q2.size(), q4.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int base;
        int lat;
        bit seen;
        op = '0; rm = '0; a = '0; mask = '0; tag = '0;
        iv2 = 1'b0; iv4 = 1'b0; ordy2 = 1'b1; ordy4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", DW'(ov4), DW'(0));
        check("rst_result", res4, '0);
        check("rst_fflags", DW'(ff4), DW'(0));
        check("rst_mask", DW'(mo4), DW'(0));
        check("rst_tag", DW'(to4), DW'(0));
        check("rst_occ", DW'(occ4), DW'(0));
        check("rst_valid2", DW'(ov2), DW'(0));
        rst_n = 1'b1;
        #1;
        check("rst_ready2", DW'(ir2), DW'(1));
        check("rst_ready4", DW'(ir4), DW'(1));
        @(posedge clk); #1;

        // Latency: 1.5 RNE -> 2 inexact, visible STAGES cycles after the accept cycle.
        send(2, 3'b000, 3'b000, {96'h0, 32'h3FC00000}, 4'b0001, 8'h5A, {96'h0, 32'h2}, 5'h01);
        iv2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (ov2) seen = 1'b1;
        end
        lat = seen ? cyc - acc_cyc : -1;
        check("latency2", DW'(lat), DW'(2));
        @(posedge clk); #1;

        // Back-to-back conversions on the STAGES=2 instance.
        send(2, 3'b000, 3'b001, {32'h4F32D05E, 32'hBF800000, 32'h7FC00000, 32'h402CCCCD}, 4'b1111, 8'h11,
             {32'h7FFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000002}, 5'h11);
        send(2, 3'b000, 3'b001, {32'h4F32D05E, 32'hBF800000, 32'h7FC00000, 32'h402CCCCD}, 4'b0001, 8'h12,
             {96'h0, 32'h00000002}, 5'h01);
        send(2, 3'b001, 3'b000, {96'h0, 32'hBF800000}, 4'b0001, 8'h13, '0, 5'h10);
        send(2, 3'b101, 3'b000, {4{32'h3FC00000}}, 4'b1111, 8'h77, '0, 5'h00);
        send(2, 3'b000, 3'b010, {32'hCF000000, 32'h00000000, 32'h40200000, 32'hBFC00000}, 4'b1111, 8'h14,
             {32'h80000000, 32'h00000000, 32'h00000002, 32'hFFFFFFFE}, 5'h01);
        send(2, 3'b000, 3'b100, {32'h4F000000, 32'h3ECCCCCD, 32'h40200000, 32'hBFC00000}, 4'b1111, 8'h15,
             {32'h7FFFFFFF, 32'h00000000, 32'h00000003, 32'hFFFFFFFE}, 5'h11);
        drain();
        check("dut2_count", DW'(nout2), DW'(7));

        // Backpressure on STAGES=4: only four of six are accepted while the output stalls.
        ordy4 = 1'b0;
        acc = 0;
        base = nout4;
        for (int c = 0; c < 10; c++) begin
            if (acc < 6) begin
                set_tx(3'b000, 3'b000, {4{flt[acc]}}, 4'hF, 8'(16 + acc));
                iv4 = 1'b1;
            end else iv4 = 1'b0;
            @(negedge clk);
            if (iv4 && ir4) begin
                q4.push_back(exp_t'({{4{32'(acc + 1)}}, 5'h00, 4'hF, 8'(16 + acc)}));
                acc++;
            end
            @(posedge clk); #1;
        end
        check("bp_accepted", DW'(acc), DW'(4));
        check("bp_occ_full", DW'(occ4), DW'(4));
        check("bp_ready_low", DW'(ir4), DW'(0));
        ordy4 = 1'b1;
        #1;
        check("bp_ready_pass", DW'(ir4), DW'(1));
        for (int c = 0; c < 20 && acc < 6; c++) begin
            set_tx(3'b000, 3'b000, {4{flt[acc]}}, 4'hF, 8'(16 + acc));
            iv4 = 1'b1;
            @(negedge clk);
            if (ir4) begin
                q4.push_back(exp_t'({{4{32'(acc + 1)}}, 5'h00, 4'hF, 8'(16 + acc)}));
                acc++;
            end
            @(posedge clk); #1;
        end
        drain();
        check("bp_out_count", DW'(nout4 - base), DW'(6));

        // Bubble collapse: B closes up behind a stalled A.
        ordy4 = 1'b0;
        send(4, 3'b000, 3'b000, {4{32'h40000000}}, 4'hF, 8'hA1, {4{32'd2}}, 5'h00);
        idle(2);
        send(4, 3'b000, 3'b000, {4{32'h40400000}}, 4'hF, 8'hB2, {4{32'd3}}, 5'h00);
        idle(6);
        check("bubble_occ", DW'(occ4), DW'(2));
        check("bubble_ready", DW'(ir4), DW'(1));
        ordy4 = 1'b1;
        @(negedge clk);
        check("bubble_first_valid", DW'(ov4), DW'(1));
        check("bubble_first_tag", DW'(to4), DW'(8'hA1));
        @(negedge clk);
        check("bubble_second_valid", DW'(ov4), DW'(1));
        check("bubble_second_tag", DW'(to4), DW'(8'hB2));
        @(posedge clk); #1;
        drain();

        // Mid-flight reset discards everything in the pipe.
        ordy4 = 1'b0;
        send(4, 3'b000, 3'b000, {4{32'h3F800000}}, 4'hF, 8'hC0, {4{32'd1}}, 5'h00);
        send(4, 3'b000, 3'b000, {4{32'h3F800000}}, 4'hF, 8'hC1, {4{32'd1}}, 5'h00);
        send(4, 3'b000, 3'b000, {4{32'h3F800000}}, 4'hF, 8'hC2, {4{32'd1}}, 5'h00);
        iv4 = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", DW'(ov4), DW'(0));
        check("midrst_occ", DW'(occ4), DW'(0));
        check("midrst_result", res4, '0);
        check("midrst_tag", DW'(to4), DW'(0));
        q4.delete();
        base = nout4;
        @(negedge clk);
        rst_n = 1'b1;
        ordy4 = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_no_stale", DW'(nout4 - base), DW'(0));
        send(4, 3'b000, 3'b001, {4{32'h40000000}}, 4'hF, 8'hC3, {4{32'd2}}, 5'h00);
        drain();
        check("midrst_recover", DW'(nout4 - base), DW'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
